pipeline_hazard_ctrl: RTL and testbench
=======================================

// Module: pipeline_hazard_ctrl
// PURPOSE
//  Central stall/flush sequencer for the 5-stage pipeline. Drives write-enables,
//  flushes and bubbles of PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers from
//  load-use hazards, taken branches and the data-memory wait handshake.
//  Keeps a memory-wait FSM with timeout and a saturating stall-cycle counter.
// PARAMETERS
//  TIMEOUT  16  max consecutive un-acked DMem cycles before ERROR (>=1)
//  CNT_W    32  width of stall-cycle counter
// PORTS
//  clock__i         in   1      clock, all state on rising edge
//  reset_n__i       in   1      async active-low reset
//  IDEX_MemRead__i  in   1      instruction in EX is a load
//  IDEX_Rt__i       in   5      load destination register
//  IFID_Rs__i       in   5      ID-stage source Rs
//  IFID_Rt__i       in   5      ID-stage source Rt
//  IFID_UsesRt__i   in   1      ID-stage instruction reads Rt
//  BranchTaken__i   in   1      branch in EX resolved taken
//  DMemReq__i       in   1      instruction in MEM accesses data memory
//  DMemAck__i       in   1      data memory completes access this cycle
//  PCWrite__o       out  1      PC update enable
//  IFIDWrite__o     out  1      IF/ID load enable
//  IFIDFlush__o     out  1      IF/ID clear to NOP
//  IDEXWrite__o     out  1      ID/EX load enable
//  IDEXFlush__o     out  1      ID/EX clear (RegWrite/MemRead/MemWrite=0)
//  EXMEMWrite__o    out  1      EX/MEM load enable
//  MEMWBBubble__o   out  1      force MEM/WB RegWrite=0 on capture
//  DMemTimeout__o   out  1      sticky: memory timeout, pipeline frozen
//  StallCount__o    out  CNT_W  cycles with PCWrite__o=0, saturating
// BEHAVIOUR
//  Reset (async): state=RUN, wait_cnt=0, StallCount=0, run_q=0. While run_q=0
//   (reset and 1st edge after release) all enables/flushes/bubble/timeout=0.
//  Outputs combinational from state+inputs (Mealy), same-cycle to pipe regs.
//  FSM RUN / MEM_WAIT / ERROR. Priority: ERROR > mem-wait > branch > load-use.
//  MEM stall (state RUN or MEM_WAIT, DMemReq=1, DMemAck=0):
//   PCWrite=IFIDWrite=IDEXWrite=EXMEMWrite=0, MEMWBBubble=1, no flushes.
//   RUN->MEM_WAIT. wait_cnt++ per un-acked cycle; on TIMEOUT-th consecutive
//   un-acked cycle next state ERROR.
//  MEM_WAIT with DMemAck=1: release cycle, all enables 1, bubble 0, branch and
//   load-use rules apply normally; ->RUN, wait_cnt=0. Ack without Req ignored.
//  Branch (no mem stall, BranchTaken=1): IFIDFlush=1, IDEXFlush=1, all
//   enables 1. Overrides load-use (wrong-path instruction squashed).
//  Branch held under mem stall stays in EX; acted on at release cycle.
//  Load-use (no stall/branch): IDEX_MemRead=1, IDEX_Rt!=0 and
//   (IDEX_Rt==IFID_Rs or (IFID_UsesRt and IDEX_Rt==IFID_Rt)):
//   PCWrite=IFIDWrite=0, IDEXFlush=1, IDEXWrite/EXMEMWrite=1. One cycle only.
//  Otherwise: all enables 1, flushes 0, bubble 0.
//  ERROR: all enables 0, bubble 1, DMemTimeout=1; exit only via reset.
//  StallCount += 1 each run_q cycle with PCWrite__o=0; saturates at all-ones.
//  Reset mid-MEM_WAIT/ERROR: immediate return to reset values.
// TESTING
//  Load r5 in EX, ID reads Rs=r5 -> 1 cycle PCWrite=IFIDWrite=0, IDEXFlush=1;
//   Rt=r0 or IFID_UsesRt=0 with Rt match -> no stall.
//  BranchTaken=1 with load-use present -> IFIDFlush=IDEXFlush=1, PCWrite=1.
//  DMemReq=1, Ack after 3 cycles -> 3 frozen cycles MEMWBBubble=1, ack cycle
//   all enables 1; StallCount=3.
//  TIMEOUT=4, Req=1, Ack never -> DMemTimeout=1 after 4th edge, sticky until
//   reset_n low; reset clears it asynchronously.
//  Branch + mem stall same cycle -> freeze wins; flushes on release cycle.
//  CNT_W=3, 9 stall cycles -> StallCount__o holds 7.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, taken-branch and
// data-memory wait handling, with memory timeout and a saturating stall counter.
module pipeline_hazard_ctrl #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 32
) (
    input  logic             clock__i,
    input  logic             reset_n__i,
    input  logic             IDEX_MemRead__i,
    input  logic [4:0]       IDEX_Rt__i,
    input  logic [4:0]       IFID_Rs__i,
    input  logic [4:0]       IFID_Rt__i,
    input  logic             IFID_UsesRt__i,
    input  logic             BranchTaken__i,
    input  logic             DMemReq__i,
    input  logic             DMemAck__i,
    output logic             PCWrite__o,
    output logic             IFIDWrite__o,
    output logic             IFIDFlush__o,
    output logic             IDEXWrite__o,
    output logic             IDEXFlush__o,
    output logic             EXMEMWrite__o,
    output logic             MEMWBBubble__o,
    output logic             DMemTimeout__o,
    output logic [CNT_W-1:0] StallCount__o
);

    localparam int unsigned WC_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [WC_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic              run_q;

    logic pc_write, ifid_write, ifid_flush, idex_write, idex_flush;
    logic exmem_write, memwb_bubble, timeout;
    logic mem_stall, load_use;

    assign mem_stall = (state_q != ERROR) && DMemReq__i && !DMemAck__i;
    assign load_use  = IDEX_MemRead__i && (IDEX_Rt__i != 5'd0) &&
                       ((IDEX_Rt__i == IFID_Rs__i) ||
                        (IFID_UsesRt__i && (IDEX_Rt__i == IFID_Rt__i)));

    always_comb begin
        pc_write     = 1'b0;
        ifid_write   = 1'b0;
        ifid_flush   = 1'b0;
        idex_write   = 1'b0;
        idex_flush   = 1'b0;
        exmem_write  = 1'b0;
        memwb_bubble = 1'b0;
        timeout      = 1'b0;
        state_d      = state_q;
        wait_cnt_d   = wait_cnt_q;

        // Everything stays idle until the first edge after reset release.
        if (run_q) begin
            if (state_q == ERROR) begin
                memwb_bubble = 1'b1;
                timeout      = 1'b1;
            end else if (mem_stall) begin
                memwb_bubble = 1'b1;
                wait_cnt_d   = wait_cnt_q + WC_W'(1);
                state_d      = (wait_cnt_q == WC_W'(TIMEOUT - 1)) ? ERROR : MEM_WAIT;
            end else begin
                pc_write    = 1'b1;
                ifid_write  = 1'b1;
                idex_write  = 1'b1;
                exmem_write = 1'b1;
                wait_cnt_d  = '0;
                state_d     = RUN;
                if (BranchTaken__i) begin
                    ifid_flush = 1'b1;
                    idex_flush = 1'b1;
                end else if (load_use) begin
                    pc_write   = 1'b0;
                    ifid_write = 1'b0;
                    idex_flush = 1'b1;
                end
            end
        end

        stall_cnt_d = stall_cnt_q;
        if (run_q && !pc_write && (stall_cnt_q != '1))
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clock__i or negedge reset_n__i) begin
        if (!reset_n__i) begin
            state_q     <= RUN;
            wait_cnt_q  <= '0;
            stall_cnt_q <= '0;
            run_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            run_q       <= 1'b1;
        end
    end

    assign PCWrite__o     = pc_write;
    assign IFIDWrite__o   = ifid_write;
    assign IFIDFlush__o   = ifid_flush;
    assign IDEXWrite__o   = idex_write;
    assign IDEXFlush__o   = idex_flush;
    assign EXMEMWrite__o  = exmem_write;
    assign MEMWBBubble__o = memwb_bubble;
    assign DMemTimeout__o = timeout;
    assign StallCount__o  = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: vector table for the combinational
// hazard rules, hand sequences for memory wait, timeout and counter saturation.
module tb_pipeline_hazard_ctrl;

    localparam int unsigned TIMEOUT = 4;
    localparam int unsigned CNT_W   = 3;

    // Output bit order: PCW IFIDW IFIDF IDEXW IDEXF EXMEMW BUB TO
    localparam logic [7:0] O_NORM = 8'b1101_0100;
    localparam logic [7:0] O_LU   = 8'b0001_1100;
    localparam logic [7:0] O_BR   = 8'b1111_1100;
    localparam logic [7:0] O_MEM  = 8'b0000_0010;
    localparam logic [7:0] O_ERR  = 8'b0000_0011;
    localparam logic [7:0] O_OFF  = 8'b0000_0000;

    logic             clk, rst_n;
    logic             memrd, uses_rt, br, req, ack;
    logic [4:0]       ex_rt, id_rs, id_rt;
    logic             pcw, ifidw, ifidf, idexw, idexf, exmemw, bub, tmo;
    logic [CNT_W-1:0] scnt;
    logic [7:0]       outs;

    int unsigned nvec = 0;
    int unsigned nerr = 0;

    pipeline_hazard_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clock__i(clk), .reset_n__i(rst_n),
        .IDEX_MemRead__i(memrd), .IDEX_Rt__i(ex_rt),
        .IFID_Rs__i(id_rs), .IFID_Rt__i(id_rt), .IFID_UsesRt__i(uses_rt),
        .BranchTaken__i(br), .DMemReq__i(req), .DMemAck__i(ack),
        .PCWrite__o(pcw), .IFIDWrite__o(ifidw), .IFIDFlush__o(ifidf),
        .IDEXWrite__o(idexw), .IDEXFlush__o(idexf), .EXMEMWrite__o(exmemw),
        .MEMWBBubble__o(bub), .DMemTimeout__o(tmo), .StallCount__o(scnt)
    );

    assign outs = {pcw, ifidw, ifidf, idexw, idexf, exmemw, bub, tmo};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       memrd;
        logic [4:0] ex_rt, id_rs, id_rt;
        logic       uses_rt, br, req, ack;
        logic [7:0] exp;
    } vec_t;

    vec_t tbl[12];

    task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: outputs got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chkcnt(input string name, input logic [CNT_W-1:0] exp);
        nvec++;
        if (scnt !== exp) begin
            nerr++;
            $display("FAIL %s: StallCount got %0d expected %0d", name, scnt, exp);
        end
    endtask

    task automatic set_in(input logic m, input logic [4:0] xr, input logic [4:0] rs,
                          input logic [4:0] rt, input logic u, input logic b,
                          input logic rq, input logic ak);
        memrd = m; ex_rt = xr; id_rs = rs; id_rt = rt;
        uses_rt = u; br = b; req = rq; ack = ak;
    endtask

    // Inputs applied just after posedge, outputs sampled on negedge, then advance.
    task automatic step(input string name, input logic [7:0] exp);
        @(negedge clk);
        chk8(name, outs, exp);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk8("reset_outs", outs, O_OFF);
        chkcnt("reset_cnt", '0);
        rst_n = 1'b1;
        #1;
        chk8("pre_run_outs", outs, O_OFF);
        @(posedge clk);
        #1;
    endtask

    initial begin
        tbl[0]  = '{"idle",          0,  0,  0,  0, 0, 0, 0, 0, O_NORM};
        tbl[1]  = '{"lu_rs",         1,  5,  5,  0, 0, 0, 0, 0, O_LU};
        tbl[2]  = '{"lu_rt",         1,  5,  3,  5, 1, 0, 0, 0, O_LU};
        tbl[3]  = '{"rt_not_used",   1,  5,  3,  5, 0, 0, 0, 0, O_NORM};
        tbl[4]  = '{"load_r0",       1,  0,  0,  0, 1, 0, 0, 0, O_NORM};
        tbl[5]  = '{"no_load",       0,  5,  5,  5, 1, 0, 0, 0, O_NORM};
        tbl[6]  = '{"br_over_lu",    1,  5,  5,  0, 0, 1, 0, 0, O_BR};
        tbl[7]  = '{"branch",        0,  0,  0,  0, 0, 1, 0, 0, O_BR};
        tbl[8]  = '{"req_ack_lu",    1,  7,  1,  7, 1, 0, 1, 1, O_LU};
        tbl[9]  = '{"ack_no_req",    0,  0,  0,  0, 0, 0, 0, 1, O_NORM};
        tbl[10] = '{"req_ack_br",    0,  0,  0,  0, 0, 1, 1, 1, O_BR};
        tbl[11] = '{"lu_r31",        1, 31, 31,  2, 0, 0, 0, 0, O_LU};

        do_reset();
        for (int i = 0; i < 12; i++) begin
            set_in(tbl[i].memrd, tbl[i].ex_rt, tbl[i].id_rs, tbl[i].id_rt,
                   tbl[i].uses_rt, tbl[i].br, tbl[i].req, tbl[i].ack);
            step(tbl[i].name, tbl[i].exp);
        end

        // Memory wait: three un-acked cycles, then release.
        do_reset();
        set_in(0, 0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) step("mem_freeze", O_MEM);
        set_in(0, 0, 0, 0, 0, 0, 1, 1);
        step("mem_release", O_NORM);
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        step("mem_after", O_NORM);
        chkcnt("mem_stallcnt", 3'd3);

        // Branch held under a memory stall; flushes only on release.
        do_reset();
        set_in(1, 5, 5, 0, 0, 1, 1, 0);
        step("br_frozen", O_MEM);
        step("br_frozen2", O_MEM);
        set_in(1, 5, 5, 0, 0, 1, 1, 1);
        step("br_release", O_BR);
        set_in(1, 5, 5, 0, 0, 0, 0, 0);
        step("lu_after_release", O_LU);

        // Timeout after TIMEOUT un-acked cycles, sticky, async reset clears.
        do_reset();
        set_in(0, 0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 4; i++) step("to_freeze", O_MEM);
        step("to_error", O_ERR);
        set_in(0, 0, 0, 0, 0, 1, 1, 1);
        step("to_sticky_ack", O_ERR);
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        step("to_sticky_idle", O_ERR);
        chkcnt("to_stallcnt", 3'd7);
        #2;
        rst_n = 1'b0;
        #1;
        chk8("to_async_clear", outs, O_OFF);
        chkcnt("to_async_cnt", '0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        step("to_after_reset", O_NORM);

        // Saturation: nine load-use stall cycles on a 3-bit counter.
        do_reset();
        set_in(1, 9, 9, 0, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) step("sat_lu", O_LU);
        chkcnt("sat_cnt6", 3'd6);
        for (int i = 0; i < 3; i++) step("sat_lu2", O_LU);
        chkcnt("sat_cnt9", 3'd7);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
